ysyx_mem_arbiter: RTL and testbench
===================================

Name: ysyx_mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single memory bus port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write).
- Sits between the IFU/LSU bus-side ports and the crossbar/SRAM interface.
- Registers the winning request, drives it downstream until the slave responds, then routes the one-cycle response back to the owner.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_araddr  in  ADDR_W  IFU fetch address
- ifu_arvalid  in  1  IFU read request
- ifu_rdata  out  DATA_W  IFU read data
- ifu_rvalid  out  1  IFU read response, 1-cycle pulse
- lsu_araddr  in  ADDR_W  LSU load address
- lsu_arvalid  in  1  LSU load request
- lsu_rstrb  in  8  LSU load byte strobe
- lsu_rdata  out  DATA_W  LSU read data
- lsu_rvalid  out  1  LSU read response, 1-cycle pulse
- lsu_awaddr  in  ADDR_W  LSU store address
- lsu_awvalid  in  1  LSU store address valid
- lsu_wdata  in  DATA_W  LSU store data
- lsu_wstrb  in  8  LSU store byte strobe
- lsu_wvalid  in  1  LSU store data valid
- lsu_wready  out  1  LSU store done, 1-cycle pulse
- bus_araddr  out  ADDR_W  downstream read address
- bus_arvalid  out  1  downstream read request
- bus_rstrb  out  8  downstream read strobe
- bus_rdata  in  DATA_W  downstream read data
- bus_rvalid  in  1  downstream read response
- bus_awaddr  out  ADDR_W  downstream write address
- bus_awvalid  out  1  downstream write address valid
- bus_wdata  out  DATA_W  downstream write data
- bus_wstrb  out  8  downstream write strobe
- bus_wvalid  out  1  downstream write data valid
- bus_wready  in  1  downstream write done
- arb_busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, IFU_RD, LSU_RD, LSU_WR, DONE.
- Reset: state=IDLE. All bus_* outputs, all response outputs and arb_busy are 0. Latched address/data/strobe registers are 0.
- IDLE: samples requests each cycle and picks at most one. A store is eligible only when lsu_awvalid & lsu_wvalid.
  - Fixed priority: LSU_WR > LSU_RD > IFU_RD. LSU wins so a load/store stalling the pipeline cannot be starved by fetch.
  - LSU store and load both valid in the same cycle: store wins. This is illegal upstream but must not hang the arbiter.
- Grant: on the chosen edge, latch the winner's address, strobe and wdata. Move to the grant state.
  - IFU reads latch rstrb=8'hf.
  - bus_*valid assert from the next cycle, giving 1-cycle request latency.
  - bus_*valid stay high and bus_* payload stays stable until the slave response.
- IFU_RD/LSU_RD: on bus_rvalid=1, the owner's rvalid is 1 in that same cycle (combinational route) and rdata = bus_rdata. Then go to DONE and deassert bus_arvalid.
- LSU_WR: on bus_wready=1, lsu_wready is 1 in that same cycle. Then go to DONE and deassert bus_awvalid/bus_wvalid.
- Responses never reach the non-owner. ifu_rdata/lsu_rdata drive bus_rdata only while the corresponding rvalid is high, 0 otherwise.
- DONE: exactly 1 cycle with no grant. Requesters must drop valid by the cycle after their response, so a stale valid is never regranted. DONE → IDLE.
- Back-to-back throughput: one transaction per (slave latency + 3) cycles minimum.
- bus_rvalid/bus_wready arriving in IDLE or DONE, or of the wrong type for the current state: ignored, no output pulse.
- Requester drops valid mid-transaction: the transaction still completes downstream. The response pulse is still delivered to the owner, which must discard it.
- rst asserted in any state: next edge returns to IDLE with all outputs 0. An in-flight response is dropped.

Optional Feature:
- YSYX_ARB_RR_EN defined: IFU_RD and LSU_RD share a round-robin pointer.
  - Pointer resets to IFU-last. It flips to the granted master after each read grant.
  - When both reads are pending, the master not granted last wins.
  - LSU_WR still has absolute priority over reads.
- Not defined: fixed priority as above.

Test Plan:
- Single IFU fetch: ifu_arvalid=1, araddr=0x3000_0000; slave answers bus_rvalid 3 cycles after bus_arvalid with 0x0000_0413 -> bus_arvalid high 1 cycle after request with rstrb=8'hf; ifu_rvalid pulses 1 cycle with 0x0000_0413; lsu_rvalid stays 0; DONE then IDLE.
- Store: lsu_awvalid=lsu_wvalid=1, addr 0x8000_0010, wdata 0xDEAD_BEEF, wstrb 8'h3; slave wready after 2 cycles -> bus_awaddr/wdata/wstrb match and stay stable while bus_awvalid is high; lsu_wready pulses once; no read activity.
- Contention: ifu_arvalid and lsu_arvalid rise in the same cycle -> LSU granted first; IFU granted after LSU's DONE. With YSYX_ARB_RR_EN, the second simultaneous pair goes to IFU.
- Store only half-valid: lsu_awvalid=1, lsu_wvalid=0 for 4 cycles while ifu_arvalid=1 -> IFU granted; store granted once lsu_wvalid rises.
- Spurious response: bus_rvalid=1 while in IDLE -> ifu_rvalid=lsu_rvalid=0, state unchanged.
- Reset mid-read: rst=1 in LSU_RD before bus_rvalid -> next cycle all outputs 0, state IDLE; a later bus_rvalid produces no pulse.

Source files
------------

// File: rtl/ysyx_mem_arbiter.sv
// ysyx_mem_arbiter: two-master (IFU/LSU) to one-slave memory bus arbiter; define YSYX_ARB_RR_EN for round-robin between reads
module ysyx_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic [ADDR_W-1:0] bus_araddr,
  output logic              bus_arvalid,
  output logic [7:0]        bus_rstrb,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic [ADDR_W-1:0] bus_awaddr,
  output logic              bus_awvalid,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [7:0]        bus_wstrb,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  output logic              arb_busy
);
  typedef enum logic [2:0] {IDLE, IFU_RD, LSU_RD, LSU_WR, DONE} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0] strb_q;
  logic st_req, pick_lsu, rd, wr;
  assign st_req = lsu_awvalid & lsu_wvalid;
`ifdef YSYX_ARB_RR_EN
  logic rr_last;
  // rr_last = 1 when the LSU held the most recent read grant
  assign pick_lsu = lsu_arvalid & (~ifu_arvalid | ~rr_last);
  always_ff @(posedge clk)
    if (rst) rr_last <= 1'b0;
    else if (state == IDLE && !st_req && (lsu_arvalid || ifu_arvalid)) rr_last <= pick_lsu;
`else
  assign pick_lsu = lsu_arvalid;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:           next = st_req ? LSU_WR : pick_lsu ? LSU_RD : ifu_arvalid ? IFU_RD : IDLE;
      IFU_RD, LSU_RD: next = bus_rvalid ? DONE : state;
      LSU_WR:         next = bus_wready ? DONE : state;
      default:        next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && next != IDLE) begin
      addr_q  <= st_req ? lsu_awaddr : pick_lsu ? lsu_araddr : ifu_araddr;
      strb_q  <= st_req ? lsu_wstrb : pick_lsu ? lsu_rstrb : 8'hf;
      wdata_q <= st_req ? lsu_wdata : '0;
    end
  always_comb begin
    rd          = state == IFU_RD || state == LSU_RD;
    wr          = state == LSU_WR;
    bus_arvalid = rd;
    bus_araddr  = rd ? addr_q : '0;
    bus_rstrb   = rd ? strb_q : '0;
    bus_awvalid = wr;
    bus_wvalid  = wr;
    bus_awaddr  = wr ? addr_q : '0;
    bus_wstrb   = wr ? strb_q : '0;
    bus_wdata   = wr ? wdata_q : '0;
    ifu_rvalid  = state == IFU_RD && bus_rvalid;
    lsu_rvalid  = state == LSU_RD && bus_rvalid;
    lsu_wready  = wr && bus_wready;
    ifu_rdata   = ifu_rvalid ? bus_rdata : '0;
    lsu_rdata   = lsu_rvalid ? bus_rdata : '0;
    arb_busy    = state != IDLE;
  end
endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb_ysyx_mem_arbiter: table-driven transactions plus hand sequences, responses checked through a scoreboard queue
module tb_ysyx_mem_arbiter;
  logic clk = 0, rst = 1;
  logic [31:0] ifu_araddr = 0, lsu_araddr = 0, lsu_awaddr = 0, lsu_wdata = 0, bus_rdata = 0;
  logic ifu_arvalid = 0, lsu_arvalid = 0, lsu_awvalid = 0, lsu_wvalid = 0, bus_rvalid = 0, bus_wready = 0;
  logic [7:0] lsu_rstrb = 0, lsu_wstrb = 0;
  logic [31:0] ifu_rdata, lsu_rdata, bus_araddr, bus_awaddr, bus_wdata;
  logic ifu_rvalid, lsu_rvalid, lsu_wready, bus_arvalid, bus_awvalid, bus_wvalid, arb_busy;
  logic [7:0] bus_rstrb, bus_wstrb;

  ysyx_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb), .lsu_rdata(lsu_rdata),
    .lsu_rvalid(lsu_rvalid), .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid), .bus_rstrb(bus_rstrb), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid), .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [31:0] ia;
    logic lrv; logic [31:0] lra; logic [7:0] lrs;
    logic awv, wv; logic [31:0] wa, wd; logic [7:0] ws;
    int lat; logic [31:0] rd;
    int own; logic [31:0] ea; logic [7:0] es; logic [31:0] ewd;
  } vec_t;
  typedef struct { logic [2:0] pulse; logic [63:0] data; } resp_t;

  vec_t vecs[7];
  resp_t sb[$];
  resp_t mon_r;
  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // own: 0 = IFU read, 1 = LSU read, 2 = LSU write
  task automatic push(input int own, input logic [31:0] rd);
    resp_t r;
    r.pulse = own == 0 ? 3'b100 : own == 1 ? 3'b010 : 3'b001;
    r.data  = own == 0 ? {rd, 32'h0} : own == 1 ? {32'h0, rd} : 64'h0;
    sb.push_back(r);
  endtask

  task automatic step();
    @(posedge clk) #1;
  endtask

  task automatic drop_all();
    ifu_arvalid = 0; lsu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0;
    bus_rvalid = 0; bus_wready = 0;
  endtask

  // Any response pulse must match the oldest outstanding expectation
  always @(negedge clk)
    if (ifu_rvalid || lsu_rvalid || lsu_wready) begin
      if (sb.size() == 0) chk("unexpected_pulse", {ifu_rvalid, lsu_rvalid, lsu_wready}, 3'b000);
      else begin
        mon_r = sb.pop_front();
        chk("resp_owner", {ifu_rvalid, lsu_rvalid, lsu_wready}, mon_r.pulse);
        chk("resp_data", {ifu_rdata, lsu_rdata}, mon_r.data);
      end
    end

  task automatic chk_payload(input vec_t v);
    if (v.own == 2) begin
      chk("wr_valids", {bus_awvalid, bus_wvalid, bus_arvalid}, 3'b110);
      chk("wr_addr", bus_awaddr, v.ea);
      chk("wr_strb", bus_wstrb, v.es);
      chk("wr_data", bus_wdata, v.ewd);
    end else begin
      chk("rd_valids", {bus_awvalid, bus_wvalid, bus_arvalid}, 3'b001);
      chk("rd_addr", bus_araddr, v.ea);
      chk("rd_strb", bus_rstrb, v.es);
    end
  endtask

  initial begin
    vecs[0] = '{1, 32'h3000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h0000_0413, 0, 32'h3000_0000, 8'hf, 0};
    vecs[1] = '{0, 0, 0, 0, 0, 1, 1, 32'h8000_0010, 32'hdead_beef, 8'h3, 2, 0, 2, 32'h8000_0010, 8'h3, 32'hdead_beef};
    vecs[2] = '{1, 32'h3000_0004, 1, 32'h8000_0100, 8'h0f, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 1, 32'h8000_0100, 8'h0f, 0};
`ifdef YSYX_ARB_RR_EN
    vecs[3] = '{1, 32'h3000_0008, 1, 32'h8000_0200, 8'h03, 0, 0, 0, 0, 0, 2, 32'hcafe_f00d, 0, 32'h3000_0008, 8'hf, 0};
`else
    vecs[3] = '{1, 32'h3000_0008, 1, 32'h8000_0200, 8'h03, 0, 0, 0, 0, 0, 2, 32'hcafe_f00d, 1, 32'h8000_0200, 8'h03, 0};
`endif
    vecs[4] = '{1, 32'h3000_000c, 1, 32'h8000_0300, 8'h01, 1, 1, 32'h8000_0400, 32'h0bad_f00d, 8'hf0, 1, 0, 2, 32'h8000_0400, 8'hf0, 32'h0bad_f00d};
    vecs[5] = '{0, 0, 1, 32'h8000_0500, 8'h0f, 1, 0, 32'h8000_0600, 32'h1111_2222, 8'hff, 2, 32'h5555_aaaa, 1, 32'h8000_0500, 8'h0f, 0};
    vecs[6] = '{1, 32'h3000_0010, 0, 0, 0, 0, 1, 32'h8000_0700, 32'h3333_4444, 8'hff, 1, 32'h0000_0013, 0, 32'h3000_0010, 8'hf, 0};

    repeat (2) step();
    rst = 0;
    chk("rst_busy", arb_busy, 0);
    chk("rst_valids", {bus_arvalid, bus_awvalid, bus_wvalid, ifu_rvalid, lsu_rvalid, lsu_wready}, 0);
    chk("rst_payload", {bus_araddr, bus_awaddr}, 0);
    step();
    chk("idle_busy", arb_busy, 0);

    foreach (vecs[i]) begin
      ifu_arvalid = vecs[i].iv; ifu_araddr = vecs[i].ia;
      lsu_arvalid = vecs[i].lrv; lsu_araddr = vecs[i].lra; lsu_rstrb = vecs[i].lrs;
      lsu_awvalid = vecs[i].awv; lsu_wvalid = vecs[i].wv;
      lsu_awaddr = vecs[i].wa; lsu_wdata = vecs[i].wd; lsu_wstrb = vecs[i].ws;
      push(vecs[i].own, vecs[i].rd);
      step();
      drop_all();
      chk("grant_busy", arb_busy, 1);
      for (int k = 0; k < vecs[i].lat; k++) begin
        chk_payload(vecs[i]);
        step();
      end
      chk_payload(vecs[i]);
      bus_rdata = vecs[i].rd;
      bus_rvalid = vecs[i].own != 2;
      bus_wready = vecs[i].own == 2;
      step();
      drop_all();
      chk("done_valids", {bus_arvalid, bus_awvalid, bus_wvalid, arb_busy}, 4'b0001);
      step();
      chk("back_idle", arb_busy, 0);
    end

    // Spurious responses while idle
    bus_rvalid = 1; bus_wready = 1; bus_rdata = 32'hffff_ffff;
    #1 chk("spur_pulse", {ifu_rvalid, lsu_rvalid, lsu_wready}, 0);
    step();
    drop_all();
    chk("spur_busy", arb_busy, 0);

    // Held contention: LSU first, IFU after DONE; a write response during a read is ignored
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0100;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0800; lsu_rstrb = 8'h0f;
    push(1, 32'haaaa_0001); push(0, 32'hbbbb_0002);
    step();
    chk("cont_lsu_addr", bus_araddr, 32'h8000_0800);
    bus_rvalid = 1; bus_rdata = 32'haaaa_0001;
    step();
    bus_rvalid = 0; lsu_arvalid = 0;
    chk("cont_done", {bus_arvalid, arb_busy}, 2'b01);
    step();
    chk("cont_idle", arb_busy, 0);
    step();
    chk("cont_ifu_addr", bus_araddr, 32'h3000_0100);
    chk("cont_ifu_strb", bus_rstrb, 8'hf);
    bus_wready = 1;
    step();
    bus_wready = 0;
    chk("wrongtype_hold", {bus_arvalid, arb_busy}, 2'b11);
    bus_rvalid = 1; bus_rdata = 32'hbbbb_0002;
    step();
    drop_all();
    step();

    // Half-valid store loses to IFU until wvalid rises
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0900; lsu_wdata = 32'h5a5a_5a5a; lsu_wstrb = 8'h0f;
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0200;
    push(0, 32'h0000_0093);
    step();
    chk("half_ifu", {bus_arvalid, bus_awvalid, bus_araddr}, {2'b10, 32'h3000_0200});
    bus_rvalid = 1; bus_rdata = 32'h0000_0093;
    step();
    bus_rvalid = 0; ifu_arvalid = 0;
    step();
    chk("half_idle1", arb_busy, 0);
    step();
    chk("half_idle2", arb_busy, 0);
    lsu_wvalid = 1;
    push(2, 0);
    step();
    chk("half_store", {bus_awvalid, bus_wvalid, bus_awaddr, bus_wdata}, {2'b11, 32'h8000_0900, 32'h5a5a_5a5a});
    bus_rvalid = 1;
    step();
    bus_rvalid = 0;
    chk("half_store_hold", {bus_awvalid, bus_wstrb}, {1'b1, 8'h0f});
    bus_wready = 1;
    step();
    drop_all();
    chk("half_done", {bus_awvalid, arb_busy}, 2'b01);
    step();

    // Reset during an LSU read drops the transaction
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0a00; lsu_rstrb = 8'h01;
    step();
    chk("rr_pre_rst", {bus_arvalid, bus_araddr}, {1'b1, 32'h8000_0a00});
    rst = 1;
    step();
    rst = 0; lsu_arvalid = 0;
    chk("mid_rst_out", {bus_arvalid, bus_araddr, bus_rstrb, arb_busy}, 0);
    bus_rvalid = 1; bus_rdata = 32'hdead_0000;
    #1 chk("mid_rst_pulse", {ifu_rvalid, lsu_rvalid}, 0);
    step();
    bus_rvalid = 0;
    chk("mid_rst_idle", arb_busy, 0);
    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
